// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types.
//   pipe_ctrl_t : per-stage control bundle {en, flush}
//   ifid_t, idex_t, exmem_t, memwb_t : per-bar payload structs, each carried
//     through one pipe_stage_elastic instance as a packed DATA_W payload
//   PIPE_OCC_W : width of the stage occupancy output (0..2 entries)
package cpu_types_pkg;

  localparam int PIPE_OCC_W = 2;

  typedef struct packed {
    logic en;
    logic flush;
  } pipe_ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
  } idex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
  } exmem_t;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        wb_en;
  } memwb_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk_i   : clock, rising edge
//   rst_ni  : synchronous active-low clear
//   inc_i   : add one this cycle unless already all-ones
//   count_o : current count (never wraps)
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Width-parametrised pipeline bar register with valid/ready handshake,
// flush and global hold, plus a saturating stall-cycle counter.
// Optional feature macro: PIPE_STAGE_SKID_EN
//   defined   : 2-entry elastic stage, in_ready registered (= !skid_v)
//   undefined : single entry, in_ready = !main_v || out_ready
// Ports:
//   CLK, nRST          : clock / synchronous active-low reset
//   en                 : global hold enable; 0 freezes the stage
//   flush              : squash every held entry (wins over en)
//   in_valid/in_ready/in_data    : upstream handshake + payload
//   out_valid/out_ready/out_data : downstream handshake + payload
//   occupancy          : entries held (0..1, or 0..2 with skid)
//   stall_cnt          : saturating count of out_valid && !out_ready cycles
//
// Handshake: a word moves when valid && ready are both high at a rising
// edge; a producer holding valid keeps its data stable until accepted, and
// valid never depends on ready in the same direction.
module pipe_stage_elastic
  import cpu_types_pkg::*;
#(
  parameter int              DATA_W     = 32,
  parameter int              CNT_W      = 16,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  en,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [PIPE_OCC_W-1:0] occupancy,
  output logic [CNT_W-1:0]      stall_cnt
);

  pipe_ctrl_t ctrl;
  assign ctrl = '{en: en, flush: flush};

  logic              main_v_q, main_v_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
`ifdef PIPE_STAGE_SKID_EN
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
`endif

  logic accept;
  logic consume;
  logic stall_inc;

  // Hold masks both handshake outputs so neighbours see a frozen stage.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (ctrl.en) begin
      out_valid = main_v_q;
`ifdef PIPE_STAGE_SKID_EN
      // Registered ready: no combinational path from out_ready.
      in_ready  = !skid_v_q;
`else
      in_ready  = !main_v_q || out_ready;
`endif
    end
  end

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  always_comb begin
    main_v_d    = main_v_q;
    main_data_d = main_data_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_v_d    = skid_v_q;
    skid_data_d = skid_data_q;
`endif
    if (ctrl.flush) begin
      main_v_d    = 1'b0;
      main_data_d = RESET_DATA;
`ifdef PIPE_STAGE_SKID_EN
      skid_v_d    = 1'b0;
`endif
    end else if (ctrl.en) begin
`ifdef PIPE_STAGE_SKID_EN
      // accept and skid_v are mutually exclusive since in_ready = !skid_v.
      if (consume) begin
        if (skid_v_q) begin
          main_data_d = skid_data_q;
          skid_v_d    = 1'b0;
        end else if (accept) begin
          main_data_d = in_data;
        end else begin
          main_v_d    = 1'b0;
        end
      end else if (accept) begin
        if (main_v_q) begin
          skid_v_d    = 1'b1;
          skid_data_d = in_data;
        end else begin
          main_v_d    = 1'b1;
          main_data_d = in_data;
        end
      end
`else
      if (accept) begin
        main_v_d    = 1'b1;
        main_data_d = in_data;
      end else if (consume) begin
        // Data is left in place; only the valid bit drops.
        main_v_d    = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      main_v_q    <= 1'b0;
      main_data_q <= RESET_DATA;
`ifdef PIPE_STAGE_SKID_EN
      skid_v_q    <= 1'b0;
      skid_data_q <= RESET_DATA;
`endif
    end else begin
      main_v_q    <= main_v_d;
      main_data_q <= main_data_d;
`ifdef PIPE_STAGE_SKID_EN
      skid_v_q    <= skid_v_d;
      skid_data_q <= skid_data_d;
`endif
    end
  end

  assign out_data = main_data_q;

`ifdef PIPE_STAGE_SKID_EN
  assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};
`else
  assign occupancy = {1'b0, main_v_q};
`endif

  // out_valid already carries en; a flushed cycle is not a stall.
  assign stall_inc = out_valid && !out_ready && !ctrl.flush;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i   (CLK),
    .rst_ni  (nRST),
    .inc_i   (stall_inc),
    .count_o (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic (both PIPE_STAGE_SKID_EN builds).
// Two instances share all inputs: one with CNT_W=16, one with CNT_W=3 for
// counter saturation. A queue model of the stage is compared every cycle.
module tb_pipe_stage_elastic;

  localparam int          DW   = 16;
  localparam logic [15:0] RSTD = 16'hBEEF;
`ifdef PIPE_STAGE_SKID_EN
  localparam int          CAP  = 2;
`else
  localparam int          CAP  = 1;
`endif

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          nRST, en, flush, in_valid, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid, in_ready3, out_valid3;
  logic [DW-1:0] out_data, out_data3;
  logic [1:0]    occupancy, occupancy3;
  logic [15:0]   stall_cnt;
  logic [2:0]    stall_cnt3;

  pipe_stage_elastic #(.DATA_W(DW), .CNT_W(16), .RESET_DATA(RSTD)) dut (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_elastic #(.DATA_W(DW), .CNT_W(3), .RESET_DATA(RSTD)) dut3 (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .occupancy(occupancy3), .stall_cnt(stall_cnt3)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: FIFO of held words (capacity CAP), last presented word, stall counts.
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_last;
  int unsigned   st16, st3;
  bit            m_live = 0;

  function automatic bit m_in_ready();
    if (!en) return 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    return exp_q.size() < CAP;
`else
    return (exp_q.size() == 0) || out_ready;
`endif
  endfunction

  always @(posedge CLK) begin : model_upd
    bit acc, con;
    if (!nRST) begin
      exp_q.delete();
      m_last = RSTD;
      st16   = 0;
      st3    = 0;
      m_live = 1;
    end else if (m_live) begin
      if (flush) begin
        exp_q.delete();
        m_last = RSTD;
      end else if (en) begin
        con = (exp_q.size() > 0) && out_ready;
        acc = in_valid && m_in_ready();
        if ((exp_q.size() > 0) && !out_ready) begin
          st16 = (st16 == 65535) ? st16 : st16 + 1;
          st3  = (st3 == 7) ? st3 : st3 + 1;
        end
        if (con) m_last = exp_q.pop_front();
        if (acc) exp_q.push_back(in_data);
      end
    end
  end

  always @(negedge CLK) begin : compare
    logic [DW-1:0] exp_data;
    if (m_live) begin
      exp_data = m_last;
      if (exp_q.size() > 0) exp_data = exp_q[0];
      chk("out_valid", out_valid, en && (exp_q.size() > 0));
      chk("in_ready",  in_ready,  m_in_ready());
      chk("out_data",  out_data,  exp_data);
      chk("occupancy", occupancy, exp_q.size());
      chk("stall_cnt", stall_cnt, st16);
      chk("out_data3", out_data3, exp_data);
      chk("stall_cnt3", stall_cnt3, st3);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    tick();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    nRST = 1'b0; en = 1'b1; flush = 1'b0;
    in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b0;

    // Reset with in_valid high for two edges.
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data, RSTD);
    chk("rst_stall",     stall_cnt, 0);
    chk("rst_occ",       occupancy, 0);
    nRST = 1'b1;

    // Stream 1..8 with continuous out_ready.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DW'(i), 1'b1);
      chk("stream_data",  out_data, i);
      chk("stream_valid", out_valid, 1);
    end
    drive(1'b0, 16'h0, 1'b1);
    chk("drain_valid", out_valid, 0);
    chk("drain_hold",  out_data, 8);
    chk("stream_stall", stall_cnt, 0);

    // Backpressure: hold 0xA for 5 stalled cycles.
    drive(1'b1, 16'h000A, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, 16'h0, 1'b0);
    chk("bp_stall5", stall_cnt, 5);
    chk("bp_data",   out_data, 16'h000A);
    chk("bp_in_ready", in_ready, (CAP == 2) ? 1 : 0);
`ifdef PIPE_STAGE_SKID_EN
    drive(1'b1, 16'h000B, 1'b0);
    chk("skid_occ2",     occupancy, 2);
    chk("skid_in_ready", in_ready, 0);
    chk("skid_head",     out_data, 16'h000A);
    drive(1'b0, 16'h0, 1'b1);
    chk("skid_rel_b",    out_data, 16'h000B);
    chk("skid_rel_occ",  occupancy, 1);
`else
    drive(1'b1, 16'h000B, 1'b0);
    chk("ns_occ1",     occupancy, 1);
    chk("ns_in_ready", in_ready, 0);
    drive(1'b1, 16'h000B, 1'b1);
    chk("ns_rel_b",    out_data, 16'h000B);
`endif
    chk("bp_stall6", stall_cnt, 6);
    drive(1'b0, 16'h0, 1'b1);
    chk("bp_empty", occupancy, 0);

    // Flush drops the held word and the one offered alongside it.
    drive(1'b1, 16'h0055, 1'b1);
    chk("fl_pre", out_data, 16'h0055);
    in_valid = 1'b1; in_data = 16'h0066; out_ready = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_occ",   occupancy, 0);
    chk("fl_data",  out_data, RSTD);
    chk("fl_stall", stall_cnt, 6);
    drive(1'b0, 16'h0, 1'b1);
    drive(1'b0, 16'h0, 1'b1);

    // Hold: en=0 for 3 cycles mid-stream.
    drive(1'b1, 16'h0001, 1'b1);
    drive(1'b1, 16'h0002, 1'b1);
    en = 1'b0; in_valid = 1'b1; in_data = 16'h0003; out_ready = 1'b1;
    tick(); tick(); tick();
    chk("hold_in_ready", in_ready, 0);
    chk("hold_valid",    out_valid, 0);
    chk("hold_data",     out_data, 16'h0002);
    chk("hold_occ",      occupancy, 1);
    en = 1'b1;
    drive(1'b1, 16'h0003, 1'b1);
    chk("resume_3", out_data, 16'h0003);
    drive(1'b1, 16'h0004, 1'b1);
    chk("resume_4", out_data, 16'h0004);
    drive(1'b0, 16'h0, 1'b1);

    // Flush wins while en=0.
    drive(1'b1, 16'h0009, 1'b0);
    drive(1'b1, 16'h0010, 1'b0);
    en = 1'b0; flush = 1'b1; in_valid = 1'b0;
    tick();
    en = 1'b1; flush = 1'b0;
    chk("flen_occ",  occupancy, 0);
    chk("flen_data", out_data, RSTD);

    // X on in_data with in_valid=0 must not reach out_data.
    in_valid = 1'b0; in_data = 'x; out_ready = 1'b1;
    tick(); tick();
    chk("x_block", out_data, RSTD);

    // Saturation: CNT_W=3 instance stops at 7.
    nRST = 1'b0; in_valid = 1'b0; in_data = 16'h0;
    tick();
    nRST = 1'b1;
    drive(1'b1, 16'h0007, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 16'h0, 1'b0);
    chk("sat3_7",   stall_cnt3, 7);
    chk("sat16_10", stall_cnt, 10);
    drive(1'b0, 16'h0, 1'b0);
    drive(1'b0, 16'h0, 1'b0);
    chk("sat3_stay", stall_cnt3, 7);
    chk("sat16_12",  stall_cnt, 12);
    drive(1'b0, 16'h0, 1'b1);
    drive(1'b0, 16'h0, 1'b1);

    @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
